state_ram_writer: RTL and testbench

- Write-side engine for the tile state RAM that the drawing engine reads every frame.
- Accepts tile-update commands from game logic over a valid/ready handshake and converts tile (x,y) to a word address: y*26+x.
- Performs read-modify-write on sprite layer fields, or full-word writes, and offers a whole-map clear sweep.
- Sits between game-logic FSM and the state RAM write port (port A); the drawing engine owns the read port.

---
 rtl/state_ram_pkg.sv | 13 +
 rtl/tile_addr_calc.sv | 12 +
 rtl/state_ram_writer.sv | 107 ++++++++++
 tb/tb_state_ram_writer.sv | 132 +++++++++++++
 4 files changed

// File: rtl/state_ram_pkg.sv
// state_ram_pkg: grid geometry, command ops, tile word layout and writer FSM states
package state_ram_pkg;
   localparam int unsigned GRID_W = 26;
   localparam int unsigned GRID_H = 20;
   localparam int unsigned TILES  = GRID_W * GRID_H;
   typedef enum logic [1:0] {OP_WRITE_WORD, OP_SET_SPRITE1, OP_SET_SPRITE2, OP_CLEAR_ALL} cmd_op_t;
   typedef struct packed {
      logic [10:0] sprite2;
      logic [10:0] sprite1;
      logic [9:0]  attr;
   } tile_word_t;
   typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, CLEAR} state_t;
endpackage

// File: rtl/tile_addr_calc.sv
// tile_addr_calc: tile (x,y) to state RAM word address y*GRID_W+x, plus in-range flag
module tile_addr_calc
   import state_ram_pkg::*;
(
   input  logic [4:0] x,
   input  logic [4:0] y,
   output logic [9:0] addr,
   output logic       in_range
);
   assign addr     = {5'd0, y} * 10'(GRID_W) + {5'd0, x};
   assign in_range = (32'(x) < GRID_W) && (32'(y) < GRID_H);
endmodule

// File: rtl/state_ram_writer.sv
// state_ram_writer: tile state RAM write engine (word write, sprite RMW, full clear).
// STATE_RAM_WRITER_WRCOUNT_EN adds a saturating wr_count of ram_we cycles.
module state_ram_writer
   import state_ram_pkg::*;
#(
   parameter int          RAM_LATENCY = 1,
   parameter logic [31:0] CLEAR_WORD  = 32'h0
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [4:0]  cmd_tile_x,
   input  logic [4:0]  cmd_tile_y,
   input  logic [31:0] cmd_data,
   output logic [9:0]  ram_addr,
   output logic [31:0] ram_wdata,
   output logic        ram_we,
   input  logic [31:0] ram_rdata,
   output logic        busy,
   output logic        done,
`ifdef STATE_RAM_WRITER_WRCOUNT_EN
   output logic [15:0] wr_count,
`endif
   output logic        err_range
);
   localparam logic [9:0] LAST      = 10'(TILES - 1);
   localparam logic [1:0] WAIT_INIT = 2'(RAM_LATENCY - 1);
   state_t      state;
   cmd_op_t     op;
   logic [10:0] sprite;
   logic [1:0]  wait_cnt;
   logic [9:0]  addr;
   logic        in_range;
   tile_word_t  merged;
   tile_addr_calc u_addr (.x(cmd_tile_x), .y(cmd_tile_y), .addr(addr), .in_range(in_range));
   assign cmd_ready = state == IDLE;
   assign busy      = state != IDLE;
   always_comb begin
      merged = tile_word_t'(ram_rdata);
      if (op == OP_SET_SPRITE1) merged.sprite1 = sprite;
      else merged.sprite2 = sprite;
   end
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         state     <= IDLE;
         op        <= OP_WRITE_WORD;
         sprite    <= '0;
         wait_cnt  <= '0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         ram_we    <= 1'b0;
         done      <= 1'b0;
         err_range <= 1'b0;
      end else begin
         done      <= 1'b0;
         err_range <= 1'b0;
         case (state)
            IDLE: if (cmd_valid) begin
               op     <= cmd_op_t'(cmd_op);
               sprite <= cmd_data[10:0];
               if (cmd_op_t'(cmd_op) == OP_CLEAR_ALL) begin
                  state     <= CLEAR;
                  ram_addr  <= '0;
                  ram_wdata <= CLEAR_WORD;
                  ram_we    <= 1'b1;
               end else if (!in_range) err_range <= 1'b1;
               else if (cmd_op_t'(cmd_op) == OP_WRITE_WORD) begin
                  state     <= WRITE;
                  ram_addr  <= addr;
                  ram_wdata <= cmd_data;
                  ram_we    <= 1'b1;
               end else begin
                  state    <= READ;
                  ram_addr <= addr;
               end
            end
            READ: begin
               state    <= WAIT;
               wait_cnt <= WAIT_INIT;
            end
            // rdata for ram_addr is valid in the last WAIT cycle
            WAIT: if (wait_cnt == '0) begin
               state     <= WRITE;
               ram_wdata <= merged;
               ram_we    <= 1'b1;
            end else wait_cnt <= wait_cnt - 2'd1;
            WRITE: begin
               state  <= IDLE;
               ram_we <= 1'b0;
               done   <= 1'b1;
            end
            CLEAR: if (ram_addr == LAST) begin
               state  <= IDLE;
               ram_we <= 1'b0;
               done   <= 1'b1;
            end else ram_addr <= ram_addr + 10'd1;
            default: state <= IDLE;
         endcase
      end
`ifdef STATE_RAM_WRITER_WRCOUNT_EN
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) wr_count <= '0;
      else if (ram_we && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
`endif
endmodule

// File: tb/tb_state_ram_writer.sv
// tb_state_ram_writer: scoreboard bench; stimulus pushes expected writes/events, a monitor pops them
module tb_state_ram_writer;
   localparam int LAT = 1;
   typedef struct {logic [9:0] a; logic [31:0] d;} wr_t;
   typedef struct {bit err; int c;} ev_t;
   logic        clock = 0, reset_n = 0, cmd_valid = 0;
   logic [1:0]  cmd_op = 0;
   logic [4:0]  cmd_tile_x = 0, cmd_tile_y = 0;
   logic [31:0] cmd_data = 0, ram_rdata, ram_wdata;
   logic [9:0]  ram_addr;
   logic        cmd_ready, ram_we, busy, done, err_range;
   logic [31:0] mem [0:1023];
   int          cyc = 0, nchk = 0, nerr = 0;
   wr_t         exp_wr[$];
   ev_t         exp_ev[$];
`ifdef STATE_RAM_WRITER_WRCOUNT_EN
   logic [15:0] wr_count, w0;
`endif
   state_ram_writer #(.RAM_LATENCY(LAT), .CLEAR_WORD(32'h0)) dut (
      .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_tile_x(cmd_tile_x), .cmd_tile_y(cmd_tile_y), .cmd_data(cmd_data),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
      .busy(busy), .done(done),
`ifdef STATE_RAM_WRITER_WRCOUNT_EN
      .wr_count(wr_count),
`endif
      .err_range(err_range));
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;
   always @(posedge clock) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end
   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      nchk++;
      if (a !== e) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
      end
   endtask
   initial forever begin
      ev_t e;
      wr_t w;
      @(negedge clock);
      if (ram_we) begin
         if (exp_wr.size() == 0) chk("unexpected_we", {22'd0, ram_addr, ram_wdata}, 64'd0);
         else begin
            w = exp_wr.pop_front();
            chk("ram_write", {22'd0, ram_addr, ram_wdata}, {22'd0, w.a, w.d});
         end
      end
      if (done || err_range) begin
         chk("done_err_excl", 64'(done & err_range), 64'd0);
         if (exp_ev.size() == 0) chk("unexpected_event", {62'd0, done, err_range}, 64'd0);
         else begin
            e = exp_ev.pop_front();
            chk("event_kind", 64'(err_range), 64'(e.err));
            chk("event_cycle", 64'(cyc), 64'(e.c));
         end
      end
   end
   task automatic wait_ready();
      for (int i = 0; i < 2000 && !cmd_ready; i++) @(negedge clock);
      if (!cmd_ready) chk("ready_timeout", 64'(cmd_ready), 64'd1);
   endtask
   task automatic issue(input logic [1:0] op, input logic [4:0] x, input logic [4:0] y,
                        input logic [31:0] d, input logic [9:0] ea, input logic [31:0] ew);
      bit act;
      int t;
      act = op == 2'd3 || (x < 26 && y < 20);
      wait_ready();
      t = cyc + 1;
      if (!act) exp_ev.push_back('{1'b1, t});
      else if (op == 2'd3) begin
         for (int i = 0; i < 520; i++) exp_wr.push_back('{10'(i), 32'h0});
         exp_ev.push_back('{1'b0, t + 520});
      end else begin
         exp_wr.push_back('{ea, ew});
         exp_ev.push_back('{1'b0, op == 2'd0 ? t + 1 : t + 2 + LAT});
      end
      cmd_valid = 1; cmd_op = op; cmd_tile_x = x; cmd_tile_y = y; cmd_data = d;
      @(posedge clock);
      @(negedge clock);
      cmd_valid = 0; cmd_tile_x = ~x; cmd_tile_y = ~y; cmd_data = ~d; cmd_op = ~op;
      chk("ready_after_xfer", 64'(cmd_ready), 64'(!act));
      chk("busy_after_xfer", 64'(busy), 64'(act));
   endtask
   initial begin
      repeat (2) @(negedge clock);
      chk("rst_ready", 64'(cmd_ready), 64'd1);
      chk("rst_busy", {61'd0, busy, done, err_range}, 64'd0);
      chk("rst_ram", {21'd0, ram_we, ram_addr, ram_wdata}, 64'd0);
      reset_n = 1;
      @(negedge clock);
      issue(2'd0, 5'd3, 5'd2, 32'hDEADBEEF, 10'd55, 32'hDEADBEEF);
      issue(2'd0, 5'd25, 5'd19, 32'hFFFFFFFF, 10'd519, 32'hFFFFFFFF);
      issue(2'd0, 5'd0, 5'd0, 32'h0, 10'd0, 32'h0);
      issue(2'd1, 5'd25, 5'd19, 32'h005, 10'd519, 32'hFFE017FF);
      issue(2'd2, 5'd0, 5'd0, 32'h7FF, 10'd0, 32'hFFE00000);
      issue(2'd0, 5'd26, 5'd0, 32'h1234, 10'd0, 32'h0);
      issue(2'd0, 5'd0, 5'd20, 32'h1234, 10'd0, 32'h0);
      issue(2'd1, 5'd31, 5'd31, 32'h1, 10'd0, 32'h0);
      wait_ready();
`ifdef STATE_RAM_WRITER_WRCOUNT_EN
      w0 = wr_count;
`endif
      issue(2'd3, 5'd31, 5'd31, 32'hFFFF, 10'd0, 32'h0);
      wait_ready();
`ifdef STATE_RAM_WRITER_WRCOUNT_EN
      chk("wr_count_clear", 64'(wr_count - w0), 64'd520);
`endif
      issue(2'd1, 5'd25, 5'd19, 32'h005, 10'd519, 32'h00001400);
      issue(2'd2, 5'd10, 5'd10, 32'hFFFFF801, 10'd270, 32'h00200000);
      issue(2'd3, 5'd0, 5'd0, 32'h0, 10'd0, 32'h0);
      for (int i = 0; i < 600 && !(ram_we && ram_addr == 10'd200); i++) @(negedge clock);
      chk("clear_reached_200", {53'd0, ram_we, ram_addr}, {53'd0, 1'b1, 10'd200});
      #2 reset_n = 0;
      #1 chk("we_drop_on_reset", 64'(ram_we), 64'd0);
      exp_wr.delete();
      exp_ev.delete();
      repeat (2) @(negedge clock);
      reset_n = 1;
      @(negedge clock);
      chk("post_rst_ready", {61'd0, cmd_ready, busy, done}, {61'd0, 1'b1, 1'b0, 1'b0});
      repeat (5) @(negedge clock);
      issue(2'd0, 5'd1, 5'd1, 32'h12345678, 10'd27, 32'h12345678);
      for (int i = 0; i < 100 && (exp_wr.size() != 0 || exp_ev.size() != 0); i++) @(negedge clock);
      chk("drain", 64'(exp_wr.size() + exp_ev.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
      $finish;
   end
endmodule
